memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Pipeline stage directly downstream of `execute`, consuming its ALU result and control bits.
- Performs data-memory loads and stores through a ready-based handshake; extracts and extends sub-word loads.
- Selects the write-back value and presents one registered record per instruction to the write-back stage / register file.
- Stalls upstream while a memory access is outstanding.

Parameters:
- DMEM_BASE, 32'h0010_0000, byte address of the first data-memory word.
- DMEM_SIZE, 32768, data-memory size in 32-bit words; the valid range is [DMEM_BASE, DMEM_BASE+4*DMEM_SIZE).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  execute stage presents an instruction.
- ex_result  in  32  ALU result: effective address for load/store, otherwise the result value.
- store_data  in  32  rs2 value for stores.
- pc  in  32  instruction PC.
- read_status  in  2  load size: 00 none, 01 byte, 10 half, 11 word.
- write_status  in  2  store size, same encoding as read_status.
- load_signed  in  1  1 = sign-extend the load, 0 = zero-extend.
- write_back_type  in  2  00 none, 01 ex_result, 10 load data, 11 pc+4.
- destination_register_number  in  5  rd.
- stall  out  1  upstream must hold its inputs this cycle.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned byte address (bits [1:0]=0).
- dmem_wdata  out  32  store data, lane-replicated.
- dmem_wstrb  out  4  byte enables.
- dmem_ready  in  1  memory accepts/completes the request this cycle.
- dmem_rdata  in  32  read word, valid when dmem_ready=1 and dmem_we=0.
- wb_valid  out  1  write-back record valid.
- wb_enable  out  1  write the register file.
- wb_rd  out  5  destination register.
- wb_value  out  32  write-back value.
- wb_pc  out  32  PC of the retiring instruction (stage_w_pc).
- wb_fault  out  1  misaligned, out-of-range or illegal memory op.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - dmem_req, dmem_we, wb_valid, wb_enable and wb_fault go to 0.
  - dmem_addr, dmem_wdata, wb_value and wb_pc go to 0; dmem_wstrb goes to 0; wb_rd goes to 0.
  - A reset during WAIT abandons the access: dmem_req drops on the next edge and no record is emitted.
- FSM states: IDLE, WAIT.
- IDLE, in_valid=1, no memory op (read_status=write_status=00):
  - Next edge: wb_valid=1.
  - wb_value = ex_result (type 01), pc+4 (type 11, mod 2^32), 0 (type 00/10).
  - wb_enable = (type != 00) && rd != 0.
  - Latency is 1 cycle.
- IDLE, memory op accepted:
  - Next edge: state goes to WAIT, dmem_req=1, wb_valid=0.
  - dmem_addr = {ex_result[31:2], 2'b00}; dmem_we = (write_status != 00).
  - The op and its rd, pc and extension info are latched internally.
- Fault cases, detected in IDLE:
  - Both statuses nonzero.
  - Half access with addr[0]=1.
  - Word access with addr[1:0] != 0.
  - Address outside the DMEM range.
  - Response on the next edge: no request, wb_valid=1, wb_fault=1, wb_enable=0, wb_value=0.
- Stores:
  - wstrb: byte gives 0001<<addr[1:0]; half gives 0011<<addr[1:0]; word gives 1111.
  - wdata: byte is {4{sd[7:0]}}; half is {2{sd[15:0]}}; word is sd.
- WAIT:
  - dmem_req and all dmem_* outputs are held stable until dmem_ready=1.
  - On the ready edge: dmem_req goes to 0 and state goes to IDLE.
  - Also on the ready edge: wb_valid=1 and wb_pc = latched pc.
  - Load: wb_value = dmem_rdata byte/half lane selected by addr[1:0], then sign- or zero-extended per load_signed; wb_enable = (rd != 0).
  - Store: wb_enable = 0, wb_value = 0.
  - dmem_ready while in IDLE is ignored.
- stall = (state==WAIT) && !dmem_ready, combinational.
  - In the ready cycle upstream advances; a new instruction is sampled in IDLE on the following edge, giving back-to-back memory ops a 1-cycle bubble.
- wb_valid is a single-cycle pulse per instruction. When in_valid=0 in IDLE, wb_valid=0 next cycle and the other wb_* outputs hold their last values.

Test Plan:
- ALU op: ex_result=0x1234, type 01, rd=5 -> next cycle wb_valid=1, wb_enable=1, wb_value=0x1234. Same with rd=0 -> wb_enable=0.
- JAL retire: pc=0x100, type 11, rd=1 -> wb_value=0x104, wb_pc=0x100.
- Signed byte load: addr=0x0010_0003, rdata=0x80FF_FF7F, ready held low 2 cycles -> stall high for 3 cycles including the ready cycle's predecessor, dmem_addr=0x0010_0000, wb_value=0xFFFF_FF80. Unsigned -> 0x0000_0080.
- Half store: addr=0x0010_0006, sd=0xAABB_CCDD -> dmem_we=1, wstrb=1100, wdata=0xCCDD_CCDD; wb_valid=1 with wb_enable=0 after ready.
- Faults: word load at 0x0010_0002; byte load at 0x0000_0000; read_status=01 with write_status=01 -> no dmem_req, wb_fault=1, wb_enable=0.
- Reset mid-WAIT: assert reset_n=0 while dmem_req=1 -> next edge dmem_req=0, wb_valid=0, state IDLE; then a normal ALU op retires correctly.

Source files
------------

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues data-memory loads/stores over a ready
// handshake and presents one registered write-back record per instruction.
module memory_access #(
   parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
   parameter int unsigned DMEM_SIZE = 32768
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   input  logic [31:0] ex_result,
   input  logic [31:0] store_data,
   input  logic [31:0] pc,
   input  logic [1:0]  read_status,
   input  logic [1:0]  write_status,
   input  logic        load_signed,
   input  logic [1:0]  write_back_type,
   input  logic [4:0]  destination_register_number,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_enable,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_value,
   output logic [31:0] wb_pc,
   output logic        wb_fault
);

   localparam logic [31:0] DMEM_END = DMEM_BASE + 32'(DMEM_SIZE) * 32'd4;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        wbv_q, wbv_d, wben_q, wben_d, wbf_q, wbf_d;
   logic [4:0]  wbrd_q, wbrd_d, lrd_q, lrd_d;
   logic [31:0] wbval_q, wbval_d, wbpc_q, wbpc_d, lpc_q, lpc_d;
   logic [1:0]  lsize_q, lsize_d, loff_q, loff_d;
   logic        lsigned_q, lsigned_d;

   logic        mem_op, fault, misalign, out_range;
   logic [1:0]  size, off;
   logic [31:0] st_wdata, shifted, load_val;
   logic [3:0]  st_wstrb;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign mem_op    = (|read_status) || (|write_status);
   assign size      = (|read_status) ? read_status : write_status;
   assign off       = ex_result[1:0];
   assign misalign  = ((size == 2'b10) && off[0]) || ((size == 2'b11) && (off != 2'b00));
   assign out_range = (ex_result < DMEM_BASE) || (ex_result >= DMEM_END);
   assign fault     = ((|read_status) && (|write_status)) || misalign || out_range;

   always_comb begin
      st_wstrb = '0;
      st_wdata = '0;
      case (write_status)
         2'b01: begin st_wstrb = 4'b0001 << off; st_wdata = {4{store_data[7:0]}};  end
         2'b10: begin st_wstrb = 4'b0011 << off; st_wdata = {2{store_data[15:0]}}; end
         2'b11: begin st_wstrb = 4'b1111;        st_wdata = store_data;            end
         default: ;
      endcase
   end

   // Lane extraction uses the offset latched at issue, not the live address.
   assign shifted = dmem_rdata >> {loff_q, 3'b000};
   assign byte_v  = shifted[7:0];
   assign half_v  = loff_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   always_comb begin
      case (lsize_q)
         2'b01:   load_val = {{24{lsigned_q & byte_v[7]}}, byte_v};
         2'b10:   load_val = {{16{lsigned_q & half_v[15]}}, half_v};
         default: load_val = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wbv_d     = 1'b0;
      wben_d    = wben_q;
      wbf_d     = wbf_q;
      wbrd_d    = wbrd_q;
      wbval_d   = wbval_q;
      wbpc_d    = wbpc_q;
      lrd_d     = lrd_q;
      lpc_d     = lpc_q;
      lsize_d   = lsize_q;
      loff_d    = loff_q;
      lsigned_d = lsigned_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (!mem_op) begin
                  wbv_d  = 1'b1;
                  wbf_d  = 1'b0;
                  wbrd_d = destination_register_number;
                  wbpc_d = pc;
                  wben_d = (write_back_type != 2'b00) && (destination_register_number != 5'd0);
                  case (write_back_type)
                     2'b01:   wbval_d = ex_result;
                     2'b11:   wbval_d = pc + 32'd4;
                     default: wbval_d = '0;
                  endcase
               end else if (fault) begin
                  wbv_d   = 1'b1;
                  wbf_d   = 1'b1;
                  wben_d  = 1'b0;
                  wbval_d = '0;
                  wbrd_d  = destination_register_number;
                  wbpc_d  = pc;
               end else begin
                  state_d   = WAIT;
                  req_d     = 1'b1;
                  we_d      = |write_status;
                  addr_d    = {ex_result[31:2], 2'b00};
                  wstrb_d   = st_wstrb;
                  wdata_d   = st_wdata;
                  lrd_d     = destination_register_number;
                  lpc_d     = pc;
                  lsize_d   = size;
                  loff_d    = off;
                  lsigned_d = load_signed;
               end
            end
         end
         WAIT: begin
            if (dmem_ready) begin
               state_d = IDLE;
               req_d   = 1'b0;
               wbv_d   = 1'b1;
               wbf_d   = 1'b0;
               wbrd_d  = lrd_q;
               wbpc_d  = lpc_q;
               if (we_q) begin
                  wben_d  = 1'b0;
                  wbval_d = '0;
               end else begin
                  wben_d  = (lrd_q != 5'd0);
                  wbval_d = load_val;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wbv_q     <= 1'b0;
         wben_q    <= 1'b0;
         wbf_q     <= 1'b0;
         wbrd_q    <= '0;
         wbval_q   <= '0;
         wbpc_q    <= '0;
         lrd_q     <= '0;
         lpc_q     <= '0;
         lsize_q   <= '0;
         loff_q    <= '0;
         lsigned_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wbv_q     <= wbv_d;
         wben_q    <= wben_d;
         wbf_q     <= wbf_d;
         wbrd_q    <= wbrd_d;
         wbval_q   <= wbval_d;
         wbpc_q    <= wbpc_d;
         lrd_q     <= lrd_d;
         lpc_q     <= lpc_d;
         lsize_q   <= lsize_d;
         loff_q    <= loff_d;
         lsigned_q <= lsigned_d;
      end
   end

   assign stall      = (state_q == WAIT) && !dmem_ready;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign dmem_wstrb = wstrb_q;
   assign wb_valid   = wbv_q;
   assign wb_enable  = wben_q;
   assign wb_rd      = wbrd_q;
   assign wb_value   = wbval_q;
   assign wb_pc      = wbpc_q;
   assign wb_fault   = wbf_q;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: directed stimulus pushes expected
// write-back records; a negedge monitor pops and compares each wb_valid pulse.
module tb_memory_access;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [31:0] ex_result, store_data, pc;
   logic [1:0]  read_status, write_status, write_back_type;
   logic        load_signed;
   logic [4:0]  destination_register_number;
   logic        stall, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        wb_valid, wb_enable, wb_fault;
   logic [4:0]  wb_rd;
   logic [31:0] wb_value, wb_pc;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic        en;
      logic [4:0]  rd;
      logic [31:0] val;
      logic [31:0] pc;
      logic        flt;
   } rec_t;
   rec_t exp_q[$];

   memory_access #(.DMEM_BASE(32'h0010_0000), .DMEM_SIZE(32768)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .ex_result(ex_result),
      .store_data(store_data), .pc(pc), .read_status(read_status),
      .write_status(write_status), .load_signed(load_signed),
      .write_back_type(write_back_type),
      .destination_register_number(destination_register_number),
      .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_enable(wb_enable),
      .wb_rd(wb_rd), .wb_value(wb_value), .wb_pc(wb_pc), .wb_fault(wb_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (wb_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_wb: got wb_valid=1 rd=%0d value=0x%08h expected no record", wb_rd, wb_value);
         end else begin
            rec_t e;
            e = exp_q.pop_front();
            chk("wb_enable", {31'd0, wb_enable}, {31'd0, e.en});
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            chk("wb_value", wb_value, e.val);
            chk("wb_pc", wb_pc, e.pc);
            chk("wb_fault", {31'd0, wb_fault}, {31'd0, e.flt});
         end
      end
   end

   task automatic drive(input logic [31:0] ex, input logic [31:0] sd, input logic [31:0] p,
                        input logic [1:0] rs, input logic [1:0] ws, input logic sgn,
                        input logic [1:0] wbt, input logic [4:0] rd);
      ex_result = ex; store_data = sd; pc = p; read_status = rs; write_status = ws;
      load_signed = sgn; write_back_type = wbt; destination_register_number = rd;
      in_valid = 1'b1;
   endtask

   task automatic expect_rec(input logic en, input logic [4:0] rd, input logic [31:0] val,
                             input logic [31:0] p, input logic flt);
      rec_t r;
      r.en = en; r.rd = rd; r.val = val; r.pc = p; r.flt = flt;
      exp_q.push_back(r);
   endtask

   task automatic alu_op(input logic [31:0] ex, input logic [31:0] p, input logic [1:0] wbt,
                         input logic [4:0] rd, input logic exp_en, input logic [31:0] exp_val);
      drive(ex, 32'h0, p, 2'b00, 2'b00, 1'b0, wbt, rd);
      expect_rec(exp_en, rd, exp_val, p, 1'b0);
      @(posedge clk); #1 in_valid = 1'b0;
   endtask

   task automatic fault_op(input string nm, input logic [31:0] ex, input logic [1:0] rs,
                           input logic [1:0] ws, input logic [4:0] rd, input logic [31:0] p);
      drive(ex, 32'h1234_5678, p, rs, ws, 1'b0, 2'b10, rd);
      expect_rec(1'b0, rd, 32'h0, p, 1'b1);
      @(posedge clk); #1 in_valid = 1'b0;
      chk({nm, ".no_req"}, {31'd0, dmem_req}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic mem_op(input string nm, input logic [31:0] ex, input logic [31:0] sd,
                         input logic [31:0] p, input logic [1:0] rs, input logic [1:0] ws,
                         input logic sgn, input logic [4:0] rd, input int unsigned delay,
                         input logic [31:0] rdata, input logic [31:0] e_addr,
                         input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
                         input logic e_en, input logic [31:0] e_val);
      logic e_we;
      e_we = (ws != 2'b00);
      drive(ex, sd, p, rs, ws, sgn, 2'b10, rd);
      @(posedge clk); #1 in_valid = 1'b0;
      chk({nm, ".req"}, {31'd0, dmem_req}, 32'd1);
      chk({nm, ".addr"}, dmem_addr, e_addr);
      chk({nm, ".we"}, {31'd0, dmem_we}, {31'd0, e_we});
      if (e_we) begin
         chk({nm, ".wstrb"}, {28'd0, dmem_wstrb}, {28'd0, e_wstrb});
         chk({nm, ".wdata"}, dmem_wdata, e_wdata);
      end
      chk({nm, ".stall"}, {31'd0, stall}, 32'd1);
      for (int unsigned i = 0; i < delay; i++) begin
         @(posedge clk); #1;
         chk({nm, ".req_held"}, {31'd0, dmem_req}, 32'd1);
         chk({nm, ".addr_held"}, dmem_addr, e_addr);
         chk({nm, ".stall_held"}, {31'd0, stall}, 32'd1);
      end
      dmem_rdata = rdata; dmem_ready = 1'b1;
      #1;
      chk({nm, ".stall_ready"}, {31'd0, stall}, 32'd0);
      expect_rec(e_en, rd, e_val, p, 1'b0);
      @(posedge clk); #1 dmem_ready = 1'b0;
      chk({nm, ".req_drop"}, {31'd0, dmem_req}, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
      drive(32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 2'b00, 5'd0);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("rst.dmem_we", {31'd0, dmem_we}, 32'd0);
      chk("rst.dmem_addr", dmem_addr, 32'd0);
      chk("rst.dmem_wstrb", {28'd0, dmem_wstrb}, 32'd0);
      chk("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst.wb_value", wb_value, 32'd0);
      chk("rst.wb_pc", wb_pc, 32'd0);
      chk("rst.stall", {31'd0, stall}, 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      alu_op(32'h0000_1234, 32'h40, 2'b01, 5'd5, 1'b1, 32'h0000_1234);
      alu_op(32'h0000_1234, 32'h44, 2'b01, 5'd0, 1'b0, 32'h0000_1234);
      alu_op(32'h0000_0000, 32'h100, 2'b11, 5'd1, 1'b1, 32'h0000_0104);
      alu_op(32'h0000_0055, 32'h48, 2'b00, 5'd3, 1'b0, 32'h0);
      alu_op(32'h0000_0077, 32'h4C, 2'b10, 5'd4, 1'b1, 32'h0);
      alu_op(32'h0, 32'hFFFF_FFFC, 2'b11, 5'd2, 1'b1, 32'h0);
      @(posedge clk); #1;

      mem_op("lb_s", 32'h0010_0003, 32'h0, 32'h200, 2'b01, 2'b00, 1'b1, 5'd7, 2,
             32'h80FF_FF7F, 32'h0010_0000, 4'h0, 32'h0, 1'b1, 32'hFFFF_FF80);
      mem_op("lb_u", 32'h0010_0003, 32'h0, 32'h204, 2'b01, 2'b00, 1'b0, 5'd7, 0,
             32'h80FF_FF7F, 32'h0010_0000, 4'h0, 32'h0, 1'b1, 32'h0000_0080);
      mem_op("lh_s", 32'h0010_0002, 32'h0, 32'h208, 2'b10, 2'b00, 1'b1, 5'd8, 1,
             32'h80FF_FF7F, 32'h0010_0000, 4'h0, 32'h0, 1'b1, 32'hFFFF_80FF);
      mem_op("lw_end", 32'h0011_FFFC, 32'h0, 32'h20C, 2'b11, 2'b00, 1'b0, 5'd0, 0,
             32'hDEAD_BEEF, 32'h0011_FFFC, 4'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);
      mem_op("sh", 32'h0010_0006, 32'hAABB_CCDD, 32'h210, 2'b00, 2'b10, 1'b0, 5'd9, 1,
             32'h0, 32'h0010_0004, 4'b1100, 32'hCCDD_CCDD, 1'b0, 32'h0);
      mem_op("sb", 32'h0010_0001, 32'h1122_3344, 32'h214, 2'b00, 2'b01, 1'b0, 5'd9, 0,
             32'h0, 32'h0010_0000, 4'b0010, 32'h4444_4444, 1'b0, 32'h0);
      mem_op("sw", 32'h0010_0008, 32'hCAFE_F00D, 32'h218, 2'b00, 2'b11, 1'b0, 5'd9, 0,
             32'h0, 32'h0010_0008, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0);
      @(posedge clk); #1;

      fault_op("f_lw_mis", 32'h0010_0002, 2'b11, 2'b00, 5'd6, 32'h300);
      fault_op("f_lb_zero", 32'h0000_0000, 2'b01, 2'b00, 5'd6, 32'h304);
      fault_op("f_both", 32'h0010_0000, 2'b01, 2'b01, 5'd6, 32'h308);
      fault_op("f_past_end", 32'h0012_0000, 2'b01, 2'b00, 5'd6, 32'h30C);
      fault_op("f_below", 32'h000F_FFFF, 2'b01, 2'b00, 5'd6, 32'h310);
      fault_op("f_lh_mis", 32'h0010_0001, 2'b10, 2'b00, 5'd6, 32'h314);

      dmem_ready = 1'b1; dmem_rdata = 32'h5555_5555;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_ready.req", {31'd0, dmem_req}, 32'd0);
      chk("idle_ready.stall", {31'd0, stall}, 32'd0);
      dmem_ready = 1'b0;

      drive(32'h0010_0010, 32'h0, 32'h400, 2'b11, 2'b00, 1'b0, 2'b10, 5'd10);
      @(posedge clk); #1 in_valid = 1'b0;
      chk("rstw.req_before", {31'd0, dmem_req}, 32'd1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("rstw.req", {31'd0, dmem_req}, 32'd0);
      chk("rstw.wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rstw.stall", {31'd0, stall}, 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      alu_op(32'h0000_ABCD, 32'h500, 2'b01, 5'd12, 1'b1, 32'h0000_ABCD);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
